// File: rtl/obstacle_lane_engine.sv
// Moves one car per lane horizontally on a level-dependent tick; lanes are
// refreshed one per cycle in a sweep so only a single adder/wrap path exists.
module obstacle_lane_engine #(
   parameter int                      NUM_LANES        = 6,
   parameter int                      C_BASE_CAR_SPEED = 781250,
   parameter int                      H_VISIBLE_AREA   = 640,
   parameter int                      TILE_SIZE        = 32,
   parameter logic [3*NUM_LANES-1:0]  LANE_MULT        = {3'd4, 3'd2, 3'd1, 3'd2, 3'd4, 3'd2},
   parameter logic [10*NUM_LANES-1:0] LANE_INIT_X      = {10'd288, 10'd256, 10'd128, 10'd96, 10'd64, 10'd32}
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset,
   input  logic                    i_Enable,
   input  logic [NUM_LANES-1:0]    i_Reverse,
   input  logic [3:0]              i_Score,
   output logic [10*NUM_LANES-1:0] o_Car_X,
   output logic                    o_Busy,
   output logic                    o_Update_Done,
   output logic                    o_Overrun
);

   localparam logic [10:0] MAX_X  = 11'(H_VISIBLE_AREA - TILE_SIZE);
   localparam logic [19:0] BASE_P = 20'(C_BASE_CAR_SPEED);
   localparam int          IDX_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   state_t                       state_q, state_d;
   logic [19:0]                  cnt_q, cnt_d;
   logic [19:0]                  period_q, period_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic                         pending_q, pending_d;
   logic                         overrun_q, overrun_d;
   logic [NUM_LANES-1:0][9:0]    car_x_q;
   logic                         tick;
   logic                         lane_we;
   logic [9:0]                   cur_x;
   logic [2:0]                   mult;
   logic [10:0]                  x11, m11, sum11;
   logic [9:0]                   new_x;

   always_comb begin
      if (i_Score <= 4'd3)      period_d = BASE_P;
      else if (i_Score <= 4'd6) period_d = BASE_P >> 1;
      else if (i_Score <= 4'd9) period_d = BASE_P >> 2;
      else                      period_d = BASE_P >> 3;
   end

   // >= rather than == so a period shrink mid-count fires at once instead of wrapping.
   assign tick = i_Enable && (cnt_q >= period_q - 20'd1);

   always_comb begin
      cnt_d = cnt_q;
      if (i_Enable) cnt_d = tick ? 20'd0 : cnt_q + 20'd1;
   end

   assign cur_x = car_x_q[idx_q];
   assign mult  = LANE_MULT[idx_q*3 +: 3];
   assign x11   = {1'b0, cur_x};
   assign m11   = {8'd0, mult};
   assign sum11 = x11 + m11;

   always_comb begin
      new_x = cur_x;
      if (i_Reverse[idx_q]) begin
         if (x11 < m11) new_x = 10'(x11 + MAX_X - m11);
         else           new_x = 10'(x11 - m11);
      end else begin
         if (sum11 >= MAX_X) new_x = 10'(sum11 - MAX_X);
         else                new_x = 10'(sum11);
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      overrun_d = overrun_q | (tick & pending_q);
      lane_we   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick || pending_q) begin
               state_d   = S_SWEEP;
               idx_d     = '0;
               pending_d = 1'b0;
            end
         end
         S_SWEEP: begin
            lane_we = 1'b1;
            if (tick) pending_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (tick) pending_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         period_q  <= BASE_P;
         idx_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         car_x_q   <= LANE_INIT_X;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         if (lane_we) car_x_q[idx_q] <= new_x;
      end
   end

   assign o_Car_X       = car_x_q;
   assign o_Busy        = (state_q != S_IDLE);
   assign o_Update_Done = (state_q == S_DONE);
   assign o_Overrun     = overrun_q;

endmodule

// File: tb/tb_obstacle_lane_engine.sv
// Directed bench for obstacle_lane_engine with a 16-cycle base period.
module tb_obstacle_lane_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [5:0]  rev;
   logic [3:0]  score;
   logic [59:0] car_x;
   logic        busy;
   logic        done;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;

   obstacle_lane_engine #(.C_BASE_CAR_SPEED(16)) dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_Enable      (en),
      .i_Reverse     (rev),
      .i_Score       (score),
      .o_Car_X       (car_x),
      .o_Busy        (busy),
      .o_Update_Done (done),
      .o_Overrun     (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; rev = '0; score = 4'd0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_busy(input int budget, output int edges);
      edges = budget + 1;
      for (int c = 1; c <= budget; c++) begin
         step();
         if (busy) begin
            edges = c;
            break;
         end
      end
   endtask

   task automatic wait_done(input int n, input int budget, output bit ok);
      int seen = 0;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         step();
         if (done) begin
            seen++;
            if (seen == n) begin
               ok = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [9:0] exp_x [6] = '{10'd32, 10'd64, 10'd96, 10'd128, 10'd256, 10'd288};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (car_x[10*k +: 10] !== exp_x[k]) begin
            n_fail++;
            $display("FAIL reset_lane%0d got %0d expected %0d", k, car_x[10*k +: 10], exp_x[k]);
         end
      end
      n_checks++;
      if ({busy, done, overrun} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags got busy/done/ovr=%b expected 000", {busy, done, overrun});
      end
   endtask

   task automatic test_first_sweep();
      logic [9:0] exp_x [6] = '{10'd34, 10'd68, 10'd98, 10'd129, 10'd258, 10'd292};
      int edges, busy_cnt, done_cnt;
      do_reset();
      score = 4'd1; en = 1'b1;
      wait_busy(40, edges);
      n_checks++;
      if (edges !== 16) begin
         n_fail++;
         $display("FAIL first_tick got %0d cycles expected 16", edges);
      end
      busy_cnt = 1; done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (done) done_cnt++;
         if (!busy) break;
         busy_cnt++;
      end
      en = 1'b0;
      n_checks++;
      if (busy_cnt !== 7) begin
         n_fail++;
         $display("FAIL busy_len got %0d expected 7", busy_cnt);
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL done_pulses got %0d expected 1", done_cnt);
      end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (car_x[10*k +: 10] !== exp_x[k]) begin
            n_fail++;
            $display("FAIL sweep1_lane%0d got %0d expected %0d", k, car_x[10*k +: 10], exp_x[k]);
         end
      end
   endtask

   task automatic test_reverse_wrap();
      logic [9:0] exp_r [6] = '{10'd606, 10'd604, 10'd62, 10'd111, 10'd222, 10'd220};
      logic [9:0] exp_f [6] = '{10'd0, 10'd0, 10'd64, 10'd112, 10'd224, 10'd224};
      bit ok;
      do_reset();
      score = 4'd1; rev = 6'h3F; en = 1'b1;
      wait_done(17, 340, ok);
      en = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rev_sweeps got timeout expected 17 sweeps");
      end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (car_x[10*k +: 10] !== exp_r[k]) begin
            n_fail++;
            $display("FAIL rev_lane%0d got %0d expected %0d", k, car_x[10*k +: 10], exp_r[k]);
         end
      end
      rev = 6'h00; en = 1'b1;
      wait_done(1, 40, ok);
      en = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL fwd_sweep got timeout expected 1 sweep");
      end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (car_x[10*k +: 10] !== exp_f[k]) begin
            n_fail++;
            $display("FAIL fwd_wrap_lane%0d got %0d expected %0d", k, car_x[10*k +: 10], exp_f[k]);
         end
      end
   endtask

   task automatic test_enable_mid_sweep();
      logic [9:0] exp_x [6] = '{10'd34, 10'd68, 10'd98, 10'd129, 10'd258, 10'd292};
      int edges, done_cnt, stray;
      do_reset();
      score = 4'd1; en = 1'b1;
      wait_busy(40, edges);
      en = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (done) done_cnt++;
      end
      n_checks++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_sweep got done=%0d busy=%b expected 1 and 0", done_cnt, busy);
      end
      stray = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (busy) stray++;
      end
      n_checks++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL paused_tick got %0d busy cycles expected 0", stray);
      end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (car_x[10*k +: 10] !== exp_x[k]) begin
            n_fail++;
            $display("FAIL pause_lane%0d got %0d expected %0d", k, car_x[10*k +: 10], exp_x[k]);
         end
      end
      en = 1'b1;
      wait_busy(40, edges);
      en = 1'b0;
      n_checks++;
      if (edges !== 16) begin
         n_fail++;
         $display("FAIL resume_tick got %0d cycles expected 16", edges);
      end
   endtask

   task automatic test_overrun();
      int first_ovr, dropped, bad_range;
      do_reset();
      score = 4'd10; en = 1'b1;
      first_ovr = 99;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (overrun) begin
            first_ovr = c;
            break;
         end
      end
      n_checks++;
      if (first_ovr !== 6) begin
         n_fail++;
         $display("FAIL overrun_edge got %0d expected 6", first_ovr);
      end
      dropped = 0; bad_range = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (!overrun) dropped++;
         for (int k = 0; k < 6; k++)
            if (car_x[10*k +: 10] >= 10'd608) bad_range++;
      end
      n_checks++;
      if (dropped !== 0) begin
         n_fail++;
         $display("FAIL overrun_sticky got %0d low cycles expected 0", dropped);
      end
      n_checks++;
      if (bad_range !== 0) begin
         n_fail++;
         $display("FAIL lane_range got %0d out-of-range samples expected 0", bad_range);
      end
      en = 1'b0; score = 4'd0;
      for (int c = 0; c < 20; c++) step();
      n_checks++;
      if (overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_hold got %b expected 1", overrun);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear got %b expected 0", overrun);
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic [9:0] exp_p [4] = '{10'd34, 10'd68, 10'd98, 10'd128};
      logic [9:0] exp_x [6] = '{10'd32, 10'd64, 10'd96, 10'd128, 10'd256, 10'd288};
      int edges;
      do_reset();
      score = 4'd1; en = 1'b1;
      wait_busy(40, edges);
      step(); step(); step();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (car_x[10*k +: 10] !== exp_p[k]) begin
            n_fail++;
            $display("FAIL partial_lane%0d got %0d expected %0d", k, car_x[10*k +: 10], exp_p[k]);
         end
      end
      rst = 1'b1;
      step();
      rst = 1'b0; en = 1'b0;
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (car_x[10*k +: 10] !== exp_x[k]) begin
            n_fail++;
            $display("FAIL midreset_lane%0d got %0d expected %0d", k, car_x[10*k +: 10], exp_x[k]);
         end
      end
      n_checks++;
      if ({busy, overrun} !== 2'b00) begin
         n_fail++;
         $display("FAIL midreset_flags got busy/ovr=%b expected 00", {busy, overrun});
      end
   endtask

   task automatic test_period_shrink();
      int edges, gap;
      bit saw_idle;
      do_reset();
      score = 4'd3; en = 1'b1;
      for (int c = 0; c < 12; c++) step();
      score = 4'd4;
      wait_busy(20, edges);
      n_checks++;
      if (edges !== 2) begin
         n_fail++;
         $display("FAIL shrink_tick got %0d cycles expected 2", edges);
      end
      gap = 99; saw_idle = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (!busy) saw_idle = 1'b1;
         else if (saw_idle) begin
            gap = c;
            break;
         end
      end
      en = 1'b0;
      n_checks++;
      if (gap !== 8) begin
         n_fail++;
         $display("FAIL shrink_period got %0d cycles expected 8", gap);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; rev = '0; score = '0;
      test_reset();
      test_first_sweep();
      test_reverse_wrap();
      test_enable_mid_sweep();
      test_overrun();
      test_reset_mid_sweep();
      test_period_shrink();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
